dds_freq_ctrl: RTL
==================

Name: dds_freq_ctrl

Overview:
- Frequency-control front end for the DDS waveform generator.
- Synchronises and debounces the raw frequency-select key and classifies short and long presses.
- Steps through a fixed table of DDS frequency tuning words (FTWs).
- Presents the selected FTW, with a one-cycle update strobe, to the DDS phase accumulator downstream.

Parameters:
- CLK_HZ, 100_000_000, sys_clk frequency in Hz; all timing counts derive from it.
- DEBOUNCE_MS, 20, time the input must be stable before an edge is accepted.
- LONG_MS, 1000, hold time at or above which a press is classed as long.
- FTW_W, 32, tuning-word width; equals the DDS accumulator width.
- SWEEP_DIV, 10_000, sys_clk cycles between sweep increments (used only with the optional feature).

Ports:
- sys_clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- key_in  in  1  raw key, active-low (0 = pressed), asynchronous to sys_clk
- ftw  out  FTW_W  current frequency tuning word to the DDS
- ftw_valid  out  1  one-cycle pulse whenever ftw changes value
- freq_idx  out  2  current table index, 0..3
- sweep_active  out  1  high while sweep mode is running; tied 0 when the feature is compiled out

Behaviour:
- One clock, sys_clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: ftw = FTW_TABLE[0], ftw_valid = 0, freq_idx = 0, sweep_active = 0, FSM in IDLE, synchroniser flops = 1 (released).
- key_in passes through a 2-flop synchroniser; all logic uses the synchronised signal key_s.
- Derived counts: DB_CYC = CLK_HZ/1000*DEBOUNCE_MS and LONG_CYC = CLK_HZ/1000*LONG_MS.
- Hold counter: 32-bit, saturates at LONG_CYC and never wraps.
- FSM states:
  - IDLE: key_s = 0 -> DB_PRESS, counter cleared.
  - DB_PRESS: key_s = 1 before DB_CYC -> IDLE (glitch, no action). Counter reaches DB_CYC-1 with key_s = 0 -> HELD, hold counter cleared.
  - HELD: hold counter increments each cycle. key_s = 1 -> DB_REL.
  - DB_REL: key_s = 0 before DB_CYC -> HELD; the hold count is preserved and keeps counting. Stable high for DB_CYC -> classify and return to IDLE.
- Classification happens at the DB_REL exit, in the same cycle:
  - Short press (hold < LONG_CYC): freq_idx <= freq_idx+1, wrapping 3 -> 0; ftw <= FTW_TABLE[next idx].
  - Long press: handled as described under Optional Feature.
- Latency and strobe: ftw and freq_idx update on the clock edge after the DB_REL exit condition. ftw_valid is high for exactly that one cycle.
- A press that occurs while an update is in flight is ignored until the FSM returns to IDLE.
- Reset asserted mid-press: immediate return to reset values, with no strobe.

Optional Feature:
- Macro: DDS_FREQ_CTRL_SWEEP_EN.
- Defined:
  - A long press toggles sweep_active.
  - Entering sweep: ftw <= FTW_TABLE[0] and freq_idx <= 0.
  - While sweeping: every SWEEP_DIV cycles, ftw <= ftw + SWEEP_STEP, with ftw_valid pulsing on each step. Once ftw would exceed FTW_TABLE[3], it wraps back to FTW_TABLE[0].
  - Short presses are ignored while sweeping.
  - Leaving sweep: ftw <= FTW_TABLE[freq_idx], ftw_valid pulses, sweep_active = 0.
- Undefined: a long press is treated exactly as a short press, no sweep logic is synthesised, and sweep_active is tied 0.

Decomposition:
- Package dds_freq_pkg holds:
  - FTW_TABLE[0..3] = 42950, 429497, 4294967, 42949673 (1 kHz, 10 kHz, 100 kHz and 1 MHz at 100 MHz).
  - SWEEP_STEP = 42950.
  - Enum for the FSM states IDLE, DB_PRESS, HELD, DB_REL.
- Sub-module key_debounce contains the synchroniser, debounce and release FSM. It emits short_pulse and long_pulse.
- The parent dds_freq_ctrl holds the index, FTW register, strobe and sweep logic.

Test Plan (CLK_HZ=100_000, so DB_CYC = 2000 and LONG_CYC = 100_000; SWEEP_DIV = 100):
- Reset released, no key -> ftw = 42950, freq_idx = 0, ftw_valid never asserts.
- Glitch: key low for 500 cycles, then high -> no state change, no strobe.
- 4 short presses (low for 10_000 cycles, then high for 5000 cycles) -> freq_idx 1, 2, 3, 0; ftw 429497, 4294967, 42949673, 42950; exactly one ftw_valid pulse each, DB_CYC+1 cycles after release.
- Release bounce: high for 1000 cycles, low for 1000 cycles, then high -> a single increment only.
- Without macro, long press (120_000 cycles) -> behaves as a short press, idx +1. With DDS_FREQ_CTRL_SWEEP_EN -> sweep_active = 1 and ftw steps by 42950 every 100 cycles. A second long press -> sweep_active = 0, ftw = FTW_TABLE[freq_idx].
- rst_n pulled low during HELD -> all outputs return to reset values asynchronously; a subsequent release produces no strobe.

Source files
------------

// File: rtl/dds_freq_pkg.sv
// Shared definitions for the DDS frequency-control front end:
// tuning-word table, sweep step and debounce FSM state encoding.
package dds_freq_pkg;

  // 1 kHz, 10 kHz, 100 kHz, 1 MHz at a 100 MHz accumulator clock
  localparam logic [31:0] FTW_TABLE [4] = '{32'd42950, 32'd429497, 32'd4294967, 32'd42949673};

  localparam logic [31:0] SWEEP_STEP = 32'd42950;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } db_state_e;

endpackage

// File: rtl/key_debounce.sv
// Key synchroniser, press/release debounce and short/long classification.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | key released, waiting for a press
//   DB_PRESS | key low, waiting DB_CYC cycles of stable low
//   HELD     | press accepted, hold time accumulating
//   DB_REL   | key high, waiting DB_CYC cycles of stable high
//
// short_pulse / long_pulse are single-cycle, asserted in the cycle the
// release debounce completes.
module key_debounce
  import dds_freq_pkg::*;
#(
  parameter int unsigned DB_CYC   = 2_000_000,
  parameter int unsigned LONG_CYC = 100_000_000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic key_in,
  output logic short_pulse,
  output logic long_pulse
);

  logic        sync_1, key_s;
  db_state_e   state, state_nxt;
  logic [31:0] db_cnt;
  logic [31:0] hold_cnt;

  localparam logic [31:0] DB_LAST  = 32'(DB_CYC - 1);
  localparam logic [31:0] LONG_LIM = 32'(LONG_CYC);

  // Two-flop synchroniser, resets to the released level
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      key_s  <= 1'b1;
    end else begin
      sync_1 <= key_in;
      key_s  <= sync_1;
    end
  end

  // State register plus debounce and saturating hold counters
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      db_cnt   <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE:     db_cnt <= '0;
        DB_PRESS: db_cnt <= db_cnt + 32'd1;
        HELD:     db_cnt <= '0;
        DB_REL:   db_cnt <= key_s ? db_cnt + 32'd1 : '0;
        default:  db_cnt <= '0;
      endcase
      // hold time keeps running through release bounce
      if (state == DB_PRESS) begin
        hold_cnt <= '0;
      end else if ((state == HELD || state == DB_REL) && hold_cnt < LONG_LIM) begin
        hold_cnt <= hold_cnt + 32'd1;
      end
    end
  end

  // Next-state decode and classification strobes
  always_comb begin
    state_nxt   = state;
    short_pulse = 1'b0;
    long_pulse  = 1'b0;
    case (state)
      IDLE: begin
        if (!key_s) state_nxt = DB_PRESS;
      end
      DB_PRESS: begin
        if (key_s)                 state_nxt = IDLE;
        else if (db_cnt == DB_LAST) state_nxt = HELD;
      end
      HELD: begin
        if (key_s) state_nxt = DB_REL;
      end
      DB_REL: begin
        if (!key_s) begin
          state_nxt = HELD;
        end else if (db_cnt == DB_LAST) begin
          state_nxt = IDLE;
          if (hold_cnt >= LONG_LIM) long_pulse  = 1'b1;
          else                      short_pulse = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/dds_freq_ctrl.sv
// DDS frequency-control front end: table index, FTW register, update strobe.
// Optional frequency sweep on long press is built when the macro
// DDS_FREQ_CTRL_SWEEP_EN is defined; otherwise a long press acts as a short one.
module dds_freq_ctrl
  import dds_freq_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned FTW_W       = 32,
  parameter int unsigned SWEEP_DIV   = 10_000
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             key_in,
  output logic [FTW_W-1:0] ftw,
  output logic             ftw_valid,
  output logic [1:0]       freq_idx,
  output logic             sweep_active
);

  localparam int unsigned DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned LONG_CYC = CLK_HZ / 1000 * LONG_MS;

  logic short_pulse, long_pulse;

  key_debounce #(
    .DB_CYC   (DB_CYC),
    .LONG_CYC (LONG_CYC)
  ) u_key_debounce (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse)
  );

`ifdef DDS_FREQ_CTRL_SWEEP_EN
  logic             sweep_q;
  logic [31:0]      sweep_cnt;
  logic [FTW_W-1:0] ftw_step;

  assign ftw_step     = ftw + FTW_W'(SWEEP_STEP);
  assign sweep_active = sweep_q;

  // Index/FTW register with sweep toggling on long press
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw       <= FTW_W'(FTW_TABLE[0]);
      ftw_valid <= 1'b0;
      freq_idx  <= 2'd0;
      sweep_q   <= 1'b0;
      sweep_cnt <= '0;
    end else begin
      ftw_valid <= 1'b0;
      if (long_pulse) begin
        sweep_cnt <= '0;
        ftw_valid <= 1'b1;
        if (sweep_q) begin
          sweep_q <= 1'b0;
          ftw     <= FTW_W'(FTW_TABLE[freq_idx]);
        end else begin
          sweep_q  <= 1'b1;
          freq_idx <= 2'd0;
          ftw      <= FTW_W'(FTW_TABLE[0]);
        end
      end else if (sweep_q) begin
        if (sweep_cnt == 32'(SWEEP_DIV - 1)) begin
          sweep_cnt <= '0;
          ftw_valid <= 1'b1;
          ftw <= (ftw_step > FTW_W'(FTW_TABLE[3])) ? FTW_W'(FTW_TABLE[0]) : ftw_step;
        end else begin
          sweep_cnt <= sweep_cnt + 32'd1;
        end
      end else if (short_pulse) begin
        freq_idx  <= freq_idx + 2'd1;
        ftw       <= FTW_W'(FTW_TABLE[freq_idx + 2'd1]);
        ftw_valid <= 1'b1;
      end
    end
  end
`else
  assign sweep_active = 1'b0;

  // Index/FTW register; long and short presses both step the table
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw       <= FTW_W'(FTW_TABLE[0]);
      ftw_valid <= 1'b0;
      freq_idx  <= 2'd0;
    end else begin
      ftw_valid <= 1'b0;
      if (short_pulse || long_pulse) begin
        freq_idx  <= freq_idx + 2'd1;
        ftw       <= FTW_W'(FTW_TABLE[freq_idx + 2'd1]);
        ftw_valid <= 1'b1;
      end
    end
  end
`endif

endmodule
